// File: rtl/frame_reader.sv
// Frame reader: pulls a header plus N data words from a readout FIFO, forwards
// them over a valid/ready stream and appends a 16-bit XOR checksum.
module frame_reader #(
  parameter int TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FIFO_EMPTY,
  input  logic [15:0] FIFO_Q,
  output logic        FIFO_RDEN,
  output logic [15:0] TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        FRAME_ERR
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 11) ? $clog2(TIMEOUT + 1) : 11;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, HDR_WAIT, SEND_HDR, DATA_RD, DATA_WAIT, SEND_DATA, SEND_CSUM
  } state_t;

  state_t        state;
  logic [7:0]    remaining;
  logic [15:0]   csum;
  logic [CW-1:0] empty_cnt;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          tx_acc;

  assign cnt_inc     = (&empty_cnt) ? empty_cnt : empty_cnt + CW'(1);
  assign timeout_hit = FIFO_EMPTY && (cnt_inc >= TO_LIM);
  assign tx_acc      = TX_VALID && TX_READY;
  assign BUSY        = (state != IDLE);

  // Read strobe is decoded from the state register so the FIFO word lands
  // exactly in HDR_WAIT / DATA_WAIT; gating on RST keeps it quiet in reset.
  assign FIFO_RDEN = !RST && !FIFO_EMPTY && ((state == IDLE) || (state == DATA_RD));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      remaining  <= '0;
      csum       <= '0;
      empty_cnt  <= '0;
      TX_DATA    <= '0;
      TX_VALID   <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          empty_cnt <= '0;
          if (!FIFO_EMPTY) state <= HDR_WAIT;
        end
        HDR_WAIT: begin
          if (FIFO_Q[15:12] == 4'hA) begin
            remaining <= FIFO_Q[7:0];
            csum      <= FIFO_Q;
            TX_DATA   <= FIFO_Q;
            TX_VALID  <= 1'b1;
            state     <= SEND_HDR;
          end else begin
            FRAME_ERR <= 1'b1;
            state     <= IDLE;
          end
        end
        SEND_HDR: begin
          if (tx_acc) begin
            if (remaining != 8'd0) begin
              TX_VALID <= 1'b0;
              state    <= DATA_RD;
            end else begin
              // Empty frame: checksum is the header itself, keep VALID up.
              TX_DATA <= csum;
              state   <= SEND_CSUM;
            end
          end
        end
        DATA_RD: begin
          if (!FIFO_EMPTY) begin
            empty_cnt <= '0;
            state     <= DATA_WAIT;
          end else if (timeout_hit) begin
            empty_cnt <= '0;
            FRAME_ERR <= 1'b1;
            state     <= IDLE;
          end else begin
            empty_cnt <= cnt_inc;
          end
        end
        DATA_WAIT: begin
          TX_DATA  <= FIFO_Q;
          TX_VALID <= 1'b1;
          csum     <= csum ^ FIFO_Q;
          if (remaining != 8'd0) remaining <= remaining - 8'd1;
          state    <= SEND_DATA;
        end
        SEND_DATA: begin
          if (tx_acc) begin
            if (remaining != 8'd0) begin
              TX_VALID <= 1'b0;
              state    <= DATA_RD;
            end else begin
              TX_DATA <= csum;
              state   <= SEND_CSUM;
            end
          end
        end
        SEND_CSUM: begin
          if (tx_acc) begin
            TX_VALID   <= 1'b0;
            FRAME_DONE <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          TX_VALID <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: queue-backed FIFO model, scoreboard of expected
// stream words, pulse/read counters checked per scenario.
module tb_frame_reader;
  localparam int TO = 40;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FIFO_EMPTY = 1'b1;
  logic [15:0] FIFO_Q = '0;
  logic        TX_READY = 1'b0;
  logic        FIFO_RDEN, TX_VALID, BUSY, FRAME_DONE, FRAME_ERR;
  logic [15:0] TX_DATA;

  always #5 CLK = ~CLK;

  frame_reader #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_Q(FIFO_Q),
    .FIFO_RDEN(FIFO_RDEN), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
  );

  logic [15:0] fifo[$], exp_q[$], dq[$];
  int acc_cyc[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, vld_cnt = 0, err_at = 0;
  logic pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [15:0] pd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIFO model: pop on the read strobe, data visible the following cycle.
  always @(posedge CLK) begin
    cyc++;
    if (FIFO_RDEN) begin
      chk("rden_while_empty", 32'(FIFO_EMPTY), 0);
      chk("rden_while_txvalid", 32'(TX_VALID), 0);
      chk("rden_in_reset", 32'(RST), 0);
      rd_cnt++;
      if (fifo.size() > 0) FIFO_Q <= fifo.pop_front();
    end
  end

  always @(negedge CLK) FIFO_EMPTY <= (fifo.size() == 0);

  // Stream monitor and scoreboard.
  always @(negedge CLK) begin
    if (TX_VALID) vld_cnt++;
    if (FRAME_DONE) done_cnt++;
    if (FRAME_ERR) begin err_cnt++; err_at = cyc; end
    if (pv && !pr && !prst) begin
      chk("stall_valid", 32'(TX_VALID), 1);
      chk("stall_data", 32'(TX_DATA), 32'(pd));
    end
    if (TX_VALID && TX_READY && !RST) begin
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("extra_word_sb_depth", 32'(exp_q.size()), 1);
      else chk("tx_word", 32'(TX_DATA), 32'(exp_q.pop_front()));
    end
    pv = TX_VALID; pr = TX_READY; prst = RST; pd = TX_DATA;
  end

  task automatic step();
    @(posedge CLK); #2;
  endtask

  task automatic sample();
    @(negedge CLK); #1;
  endtask

  // Loads header + dq into the FIFO; expects the first nexp of those words,
  // then the XOR checksum if want_csum.
  task automatic push_frame(input logic [15:0] hdr, input int nexp, input bit want_csum);
    logic [15:0] cs;
    cs = hdr;
    fifo.push_back(hdr);
    if (nexp > 0) exp_q.push_back(hdr);
    foreach (dq[i]) begin
      fifo.push_back(dq[i]);
      cs ^= dq[i];
      if (i + 1 < nexp) exp_q.push_back(dq[i]);
    end
    if (want_csum) exp_q.push_back(cs);
    dq.delete();
  endtask

  task automatic wait_end(input string tag, input int limit);
    int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt; n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < limit) begin
      sample();
      n++;
    end
    chk({tag, "_ended"}, 32'((done_cnt != d0) || (err_cnt != e0)), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, e0, v0, n;

    // Reset with a frame already waiting: no read may be issued.
    dq = {16'h1111, 16'h2222};
    push_frame(16'hA302, 3, 1);
    repeat (3) step();
    sample();
    chk("rst_tx_valid", 32'(TX_VALID), 0);
    chk("rst_tx_data", 32'(TX_DATA), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(FRAME_DONE), 0);
    chk("rst_err", 32'(FRAME_ERR), 0);
    chk("rst_rden", 32'(FIFO_RDEN), 0);
    chk("rst_rd_cnt", rd_cnt, 0);

    // Basic two-word frame.
    step(); RST = 1'b0; TX_READY = 1'b1;
    wait_end("f1", 100);
    chk("f1_done", done_cnt, 1);
    chk("f1_err", err_cnt, 0);
    chk("f1_sb_empty", 32'(exp_q.size()), 0);
    chk("f1_busy", 32'(BUSY), 0);
    chk("f1_reads", rd_cnt, 3);
    repeat (3) sample();
    chk("f1_done_single", done_cnt, 1);

    // N=0: header then header-as-checksum, no further reads.
    r0 = rd_cnt; d0 = done_cnt;
    step(); push_frame(16'hA500, 1, 1);
    wait_end("f0", 100);
    chk("f0_done", done_cnt - d0, 1);
    repeat (5) sample();
    chk("f0_reads", rd_cnt - r0, 1);
    chk("f0_sb_empty", 32'(exp_q.size()), 0);

    // Bad marker.
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; v0 = vld_cnt;
    step(); push_frame(16'h5302, 0, 0);
    wait_end("bad", 100);
    chk("bad_err", err_cnt - e0, 1);
    chk("bad_done", done_cnt - d0, 0);
    chk("bad_reads", rd_cnt - r0, 1);
    chk("bad_no_valid", vld_cnt - v0, 0);
    chk("bad_busy", 32'(BUSY), 0);

    // Header stalled by downstream for 10 cycles.
    r0 = rd_cnt; d0 = done_cnt;
    step(); TX_READY = 1'b0;
    dq = {16'h0BEE};
    push_frame(16'hA101, 2, 1);
    for (int i = 0; i < 20 && !TX_VALID; i++) sample();
    chk("stall_hdr_valid", 32'(TX_VALID), 1);
    repeat (10) begin
      sample();
      chk("stall_hdr_data", 32'(TX_DATA), 'hA101);
    end
    chk("stall_hdr_reads", rd_cnt - r0, 1);
    step(); TX_READY = 1'b1;
    wait_end("stall", 100);
    chk("stall_done", done_cnt - d0, 1);
    chk("stall_sb_empty", 32'(exp_q.size()), 0);

    // Throughput: one data word per 3 cycles.
    step(); acc_cyc.delete();
    dq = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
    push_frame(16'hA404, 5, 1);
    wait_end("tput", 100);
    chk("tput_accepts", 32'(acc_cyc.size()), 6);
    if (acc_cyc.size() == 6)
      for (int i = 1; i < 4; i++) chk("tput_gap", acc_cyc[i+1] - acc_cyc[i], 3);

    // Timeout after one data word.
    d0 = done_cnt; e0 = err_cnt;
    step(); acc_cyc.delete();
    dq = {16'h1234};
    push_frame(16'hA102, 2, 0);
    wait_end("to", TO + 100);
    chk("to_err", err_cnt - e0, 1);
    chk("to_done", done_cnt - d0, 0);
    chk("to_sb_empty", 32'(exp_q.size()), 0);
    chk("to_busy", 32'(BUSY), 0);
    chk("to_accepts", 32'(acc_cyc.size()), 2);
    if (acc_cyc.size() == 2) chk("to_latency", err_at - acc_cyc[1], TO + 1);

    // N=255 with random backpressure.
    r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt;
    step();
    for (int i = 0; i < 255; i++) dq.push_back(16'($urandom));
    push_frame(16'hA3FF, 256, 1);
    for (n = 0; n < 4000 && done_cnt == d0 && err_cnt == e0; n++) begin
      step();
      TX_READY = 1'($urandom_range(0, 1));
    end
    TX_READY = 1'b1;
    chk("n255_done", done_cnt - d0, 1);
    chk("n255_err", err_cnt - e0, 0);
    chk("n255_reads", rd_cnt - r0, 256);
    chk("n255_sb_empty", 32'(exp_q.size()), 0);

    // Reset in SEND_DATA, then a normal frame.
    step(); TX_READY = 1'b0;
    dq = {16'h0001, 16'h0002, 16'h0003};
    push_frame(16'hA303, 1, 0);
    for (int i = 0; i < 20 && !TX_VALID; i++) sample();
    step(); TX_READY = 1'b1;
    step(); TX_READY = 1'b0;
    for (int i = 0; i < 20 && !(TX_VALID && TX_DATA == 16'h0001); i++) sample();
    chk("mid_send_data", 32'(TX_DATA), 'h0001);
    d0 = done_cnt; e0 = err_cnt;
    step(); RST = 1'b1; fifo.delete();
    step(); RST = 1'b0;
    sample();
    chk("mid_rst_valid", 32'(TX_VALID), 0);
    chk("mid_rst_busy", 32'(BUSY), 0);
    repeat (3) sample();
    chk("mid_rst_done", done_cnt - d0, 0);
    chk("mid_rst_err", err_cnt - e0, 0);
    chk("mid_rst_sb_empty", 32'(exp_q.size()), 0);
    step(); TX_READY = 1'b1;
    dq = {16'h00FF};
    push_frame(16'hA201, 2, 1);
    wait_end("post_rst", 100);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_err", err_cnt - e0, 0);
    chk("post_rst_sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
